// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL/fabric around it.
// master = sequencer side, slave = PLL plus the logic that requests restarts.
interface pll_reset_sequencer_if #(
    parameter int RETRY_W = 4
);
    logic               sel;
    logic               restart;
    logic               locked;
    logic               pll_rst;
    logic               clkinsel;
    logic               ready;
    logic               error;
    logic               lock_lost;
    logic [RETRY_W-1:0] retries;

    modport master (
        input  sel, restart, locked,
        output pll_rst, clkinsel, ready, error, lock_lost, retries
    );

    modport slave (
        output sel, restart, locked,
        input  pll_rst, clkinsel, ready, error, lock_lost, retries
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset / input-select sequencer: keeps the PLL in reset across every CLKIN
// switch, waits for a stable lock with a timeout and retries a bounded number of times.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16,
    parameter int RETRY_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus,
    output logic [2:0]            dbg_state
);
    // sel is a level sampled every clk edge; restart is a one-cycle pulse sampled
    // on clk; locked is asynchronous and only used after the two-flop synchroniser.
    typedef enum logic [2:0] {
        S_RST_ASSERT  = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_LOCK_STABLE = 3'd2,
        S_READY       = 3'd3,
        S_ERROR       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retries, retries_nxt;
    logic               clkinsel, clkinsel_nxt;
    logic               lock_lost, lock_lost_nxt;
    logic               sync_q1, locked_s;
    logic               sel_change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= bus.locked;
            locked_s <= sync_q1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RST_ASSERT;
            cnt       <= '0;
            retries   <= '0;
            clkinsel  <= 1'b1;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retries   <= retries_nxt;
            clkinsel  <= clkinsel_nxt;
            lock_lost <= lock_lost_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        retries_nxt   = retries;
        clkinsel_nxt  = clkinsel;
        lock_lost_nxt = 1'b0;
        sel_change    = (state != S_RST_ASSERT) && (bus.sel != clkinsel);

        // The mux may only move while the PLL is held in reset.
        if (state == S_RST_ASSERT) begin
            clkinsel_nxt = bus.sel;
        end

        if (bus.restart || sel_change) begin
            state_nxt   = S_RST_ASSERT;
            cnt_nxt     = '0;
            retries_nxt = '0;
        end else begin
            case (state)
                S_RST_ASSERT: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (locked_s) begin
                        state_nxt = S_LOCK_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == LOCK_LAST) begin
                        cnt_nxt = '0;
                        if (retries == RETRY_MAX) begin
                            state_nxt = S_ERROR;
                        end else begin
                            retries_nxt = retries + RETRY_W'(1);
                            state_nxt   = S_RST_ASSERT;
                        end
                    end
                end
                S_LOCK_STABLE: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    // A dropout here is a marginal lock, not a failed attempt.
                    if (!locked_s) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_READY;
                        cnt_nxt   = '0;
                    end
                end
                S_READY: begin
                    if (!locked_s) begin
                        lock_lost_nxt = 1'b1;
                        state_nxt     = S_RST_ASSERT;
                        cnt_nxt       = '0;
                        retries_nxt   = '0;
                    end
                end
                S_ERROR: begin
                end
                default: begin
                    state_nxt   = S_RST_ASSERT;
                    cnt_nxt     = '0;
                    retries_nxt = '0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = (state == S_RST_ASSERT) || (state == S_ERROR);
    assign bus.ready     = (state == S_READY);
    assign bus.error     = (state == S_ERROR);
    assign bus.clkinsel  = clkinsel;
    assign bus.lock_lost = lock_lost;
    assign bus.retries   = retries;
    assign dbg_state     = state;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: stimulus table, hand-written corner sequences and
// random traffic, all checked against a phase/elapsed-time model of the sequencer.
module tb_pll_reset_sequencer;
  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  localparam int P_HOLD  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_READY = 3;
  localparam int P_ERR   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  pll_reset_sequencer_if #(.RETRY_W(4)) bus ();

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .CNT_W        (16),
    .RETRY_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: which phase of the sequence we are in and how many
  // cycles have elapsed in it; the synchroniser is a two-deep sample queue.
  int m_phase, m_elapsed, m_fails;
  bit m_sel_out, m_lost;
  bit lock_pipe[$];

  function automatic void model_reset();
    m_phase = P_HOLD; m_elapsed = 0; m_fails = 0; m_sel_out = 1'b1; m_lost = 1'b0;
    lock_pipe.delete();
    lock_pipe.push_back(1'b0);
    lock_pipe.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    bit ls, chg;
    if (rst) begin
      model_reset();
      return;
    end
    ls = lock_pipe.pop_front();
    lock_pipe.push_back(bus.locked);
    m_lost = 1'b0;
    chg = (m_phase != P_HOLD) && (bus.sel != m_sel_out);
    if (m_phase == P_HOLD) m_sel_out = bus.sel;
    if (bus.restart || chg) begin
      m_phase = P_HOLD; m_elapsed = 0; m_fails = 0;
      return;
    end
    m_elapsed++;
    case (m_phase)
      P_HOLD: if (m_elapsed == RST_CYCLES) begin m_phase = P_WAIT; m_elapsed = 0; end
      P_WAIT: begin
        if (ls) begin
          m_phase = P_STAB; m_elapsed = 0;
        end else if (m_elapsed == LOCK_TIMEOUT) begin
          m_elapsed = 0;
          if (m_fails == MAX_RETRIES) m_phase = P_ERR;
          else begin m_fails++; m_phase = P_HOLD; end
        end
      end
      P_STAB: begin
        if (!ls) begin m_phase = P_WAIT; m_elapsed = 0; end
        else if (m_elapsed == STABLE_CYCLES) begin m_phase = P_READY; m_elapsed = 0; end
      end
      P_READY: if (!ls) begin m_lost = 1'b1; m_phase = P_HOLD; m_elapsed = 0; m_fails = 0; end
      default: ;
    endcase
  endfunction

  function automatic void check_model();
    check("model.pll_rst", bus.pll_rst, (m_phase == P_HOLD) || (m_phase == P_ERR));
    check("model.ready", bus.ready, m_phase == P_READY);
    check("model.error", bus.error, m_phase == P_ERR);
    check("model.clkinsel", bus.clkinsel, m_sel_out);
    check("model.lock_lost", bus.lock_lost, m_lost);
    check("model.retries", bus.retries, m_fails);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, ".pll_rst"}, bus.pll_rst, 1);
    check({tag, ".clkinsel"}, bus.clkinsel, 1);
    check({tag, ".ready"}, bus.ready, 0);
    check({tag, ".error"}, bus.error, 0);
    check({tag, ".lock_lost"}, bus.lock_lost, 0);
    check({tag, ".retries"}, bus.retries, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.sel = 1'b1; bus.restart = 1'b0; bus.locked = 1'b0;
    #1;
    check_reset_values("reset");
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit sel; bit restart; bit locked; int cycles;
    bit pll_rst; bit ready; bit error; bit clkinsel; bit lock_lost; int retries;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(bit s, bit r, bit l, int n,
                                  bit p, bit rd, bit e, bit cs, bit ll, int rt);
    vec_t v;
    v.sel = s; v.restart = r; v.locked = l; v.cycles = n;
    v.pll_rst = p; v.ready = rd; v.error = e; v.clkinsel = cs; v.lock_lost = ll; v.retries = rt;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int high_cnt, rises, run_left;
    bit prev;

    // Nominal lock, lock loss, stable-window glitch, input switch while READY.
    add_vec(1,0,0, 3,  1,0,0,1,0,0);
    add_vec(1,0,0, 1,  0,0,0,1,0,0);
    add_vec(1,0,0,10,  0,0,0,1,0,0);
    add_vec(1,0,1,10,  0,0,0,1,0,0);
    add_vec(1,0,1, 1,  0,1,0,1,0,0);
    add_vec(1,0,0, 2,  0,1,0,1,0,0);
    add_vec(1,0,0, 1,  1,0,0,1,1,0);
    add_vec(1,0,0, 1,  1,0,0,1,0,0);
    add_vec(1,0,0, 2,  1,0,0,1,0,0);
    add_vec(1,0,0, 1,  0,0,0,1,0,0);
    add_vec(1,0,1, 8,  0,0,0,1,0,0);
    add_vec(1,0,0, 3,  0,0,0,1,0,0);
    add_vec(1,0,1,10,  0,0,0,1,0,0);
    add_vec(1,0,1, 1,  0,1,0,1,0,0);
    add_vec(0,0,1, 1,  1,0,0,1,0,0);
    add_vec(0,0,1, 1,  1,0,0,0,0,0);
    add_vec(0,0,1, 2,  1,0,0,0,0,0);
    add_vec(0,0,1, 1,  0,0,0,0,0,0);
    add_vec(0,0,1, 8,  0,0,0,0,0,0);
    add_vec(0,0,1, 1,  0,1,0,0,0,0);

    model_reset();
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      bus.sel = vecs[i].sel; bus.restart = vecs[i].restart; bus.locked = vecs[i].locked;
      for (int c = 0; c < vecs[i].cycles; c++) step();
      check($sformatf("vec%0d.pll_rst", i), bus.pll_rst, vecs[i].pll_rst);
      check($sformatf("vec%0d.ready", i), bus.ready, vecs[i].ready);
      check($sformatf("vec%0d.error", i), bus.error, vecs[i].error);
      check($sformatf("vec%0d.clkinsel", i), bus.clkinsel, vecs[i].clkinsel);
      check($sformatf("vec%0d.lock_lost", i), bus.lock_lost, vecs[i].lock_lost);
      check($sformatf("vec%0d.retries", i), bus.retries, vecs[i].retries);
    end
    bus.restart = 1'b0;

    // Exhausted retries: three 4-cycle reset pulses, ERROR 108 edges after release.
    do_reset();
    #1;
    prev = bus.pll_rst;
    high_cnt = bus.pll_rst ? 1 : 0;
    rises = 0;
    for (int c = 1; c < 108; c++) begin
      step();
      if (bus.pll_rst) high_cnt++;
      if (bus.pll_rst && !prev) rises++;
      prev = bus.pll_rst;
    end
    check("retry.pll_rst_high_cycles", high_cnt, 12);
    check("retry.extra_pulses", rises, 2);
    check("retry.error_before", bus.error, 0);
    step();
    check("retry.error", bus.error, 1);
    check("retry.retries", bus.retries, 2);
    check("retry.pll_rst", bus.pll_rst, 1);
    for (int c = 0; c < 20; c++) step();
    check("retry.error_held", bus.error, 1);
    check("retry.pll_rst_held", bus.pll_rst, 1);

    // Restart and select change together from ERROR give one restart.
    bus.restart = 1'b1; bus.sel = 1'b0;
    step();
    bus.restart = 1'b0;
    check("both.error", bus.error, 0);
    check("both.pll_rst", bus.pll_rst, 1);
    check("both.retries", bus.retries, 0);
    check("both.ready", bus.ready, 0);
    step();
    check("both.clkinsel", bus.clkinsel, 0);
    for (int c = 0; c < 3; c++) step();
    check("both.pll_rst_released", bus.pll_rst, 0);
    for (int c = 0; c < LOCK_TIMEOUT; c++) step();
    check("both.retries_after_timeout", bus.retries, 1);
    for (int c = 0; c < 6; c++) step();
    check("both.in_wait", bus.pll_rst, 0);

    // Asynchronous reset mid WAIT_LOCK, checked before any clock edge.
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    step();
    rst = 1'b0; bus.sel = 1'b1;

    // Random traffic against the model.
    do_reset();
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) bus.sel = ~bus.sel;
      if (run_left == 0) begin
        bus.locked = ($urandom_range(0, 3) != 0);
        run_left = bus.locked ? $urandom_range(1, 80) : $urandom_range(1, 50);
      end
      run_left--;
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0; bus.restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Control stage directly upstream of the PLLE2_ADV test harness. It drives the PLL RST and CLKINSEL pins and watches LOCKED. It switches between CLKIN1 and CLKIN2 safely by holding the PLL in reset during each switch, and waits for a stable lock with a timeout. It retries a bounded number of times and reports ready or error status to the rest of the design.

Parameters:
RST_CYCLES, 16, number of cycles O_PLL_RST is held high per reset attempt (≥2)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before the attempt is declared failed
STABLE_CYCLES, 256, cycles the synchronised lock must stay high before READY
MAX_RETRIES, 3, failed attempts tolerated after the first before ERROR
CNT_W, 16, width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)
RETRY_W, 4, width of O_RETRIES

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
I_SEL  in  1  requested PLL input (1 = CLKIN1, 0 = CLKIN2); synchronous to CLK
I_RESTART  in  1  single-cycle pulse that forces a fresh sequence
I_LOCKED  in  1  PLL LOCKED; asynchronous, double-flop synchronised internally
O_PLL_RST  out  1  to PLL RST
O_CLKINSEL  out  1  to PLL CLKINSEL
O_READY  out  1  PLL locked and stable
O_ERROR  out  1  retries exhausted
O_LOCK_LOST  out  1  one-cycle pulse when lock drops while READY
O_RETRIES  out  RETRY_W  failed attempts in the current sequence

Behaviour:
- One clock; reset is asynchronous and active-high. Ports CLK and RST.
- RST high forces the following, all registered:
  - state = RST_ASSERT, counter = 0, O_RETRIES = 0
  - O_PLL_RST = 1, O_CLKINSEL = 1, O_READY = 0, O_ERROR = 0, O_LOCK_LOST = 0
  - both sync flops = 0
- Lock synchroniser: I_LOCKED to locked_s takes 2 CLK edges. Only locked_s is used internally.
- States: RST_ASSERT, WAIT_LOCK, LOCK_STABLE, READY, ERROR.
- Event priority per cycle: RST > I_RESTART > select change (I_SEL != O_CLKINSEL) > lock/timeout events.
- I_RESTART in any state:
  - Go to RST_ASSERT next edge; counter = 0, O_RETRIES = 0.
- Select change in any state except RST_ASSERT:
  - Same action as I_RESTART.
- RST_ASSERT:
  - O_PLL_RST = 1.
  - O_CLKINSEL <= I_SEL every cycle. The PLL is held in reset, so the mux may move; the counter is not restarted by a select change here.
  - The counter increments. When counter == RST_CYCLES-1: go to WAIT_LOCK, counter = 0.
  - Net effect: O_PLL_RST is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - O_PLL_RST = 0; counter increments.
  - If locked_s = 1: go to LOCK_STABLE, counter = 0.
  - Else if counter == LOCK_TIMEOUT-1 (attempt failed):
    - If O_RETRIES == MAX_RETRIES: go to ERROR.
    - Else O_RETRIES += 1, go to RST_ASSERT, counter = 0.
- LOCK_STABLE:
  - Counter increments.
  - If locked_s = 0: go to WAIT_LOCK, counter = 0. This is not counted as a retry.
  - Else if counter == STABLE_CYCLES-1: go to READY.
- READY:
  - O_READY = 1; O_RETRIES is held for observation.
  - If locked_s = 0: O_LOCK_LOST = 1 for one cycle, O_READY drops, go to RST_ASSERT, O_RETRIES = 0.
- ERROR:
  - O_ERROR = 1, O_PLL_RST = 1, held.
  - Exit only via RST, I_RESTART, or a select change.
- O_READY and O_ERROR are state decodes and are never both high. O_PLL_RST = 1 in RST_ASSERT and ERROR only.
- Latency: I_LOCKED rising while in WAIT_LOCK gives O_READY high STABLE_CYCLES+3 edges later, provided I_LOCKED stays high.
- The counter never wraps: every compare is an equality that resets it.
- O_RETRIES saturates at MAX_RETRIES. MAX_RETRIES < 2^RETRY_W.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal lock: release RST, raise I_LOCKED 10 cycles after O_PLL_RST falls -> O_PLL_RST high exactly 4 cycles; O_READY rises 11 edges after I_LOCKED rises; O_RETRIES = 0.
2. Exhausted retries: keep I_LOCKED = 0 -> three reset pulses of 4 cycles each; O_ERROR = 1 after 3×(4+32) = 108 cycles from RST release; O_RETRIES = 2; O_PLL_RST stays 1.
3. Glitch during stable window: I_LOCKED high, then low for 3 cycles at stable count 5, then high -> returns to WAIT_LOCK with no retry; O_READY 11 edges after the second rise; O_RETRIES = 0.
4. Input switch while READY: toggle I_SEL 1->0 -> next edge O_READY = 0 and O_PLL_RST = 1; O_CLKINSEL = 0 while O_PLL_RST is high; 4-cycle reset pulse; relocks normally.
5. Lock loss while READY: drop I_LOCKED -> O_LOCK_LOST pulses exactly 1 cycle, 2–3 edges later; a new 4-cycle reset follows; no O_ERROR.
6. Simultaneous events and recovery:
   - From ERROR, assert I_RESTART and I_SEL change in the same cycle -> a single restart: RST_ASSERT, O_RETRIES = 0, O_ERROR = 0 next edge.
   - Assert RST mid-WAIT_LOCK -> all outputs take reset values immediately, without a CLK edge.
